// File: rtl/hyperbus_resp_core.sv
// Behavioural HyperBus memory responder: CA decode, fixed 2x latency, linear/wrapped bursts and CR0.
// Define HYPERBUS_RESP_MAX_BURST_EN to limit data beats per CS window to MaxBurst.
module hyperbus_resp_core #(
  parameter int unsigned AddrWidth     = 10,
  parameter int unsigned LatencyCycles = 6,
  parameter int unsigned BurstWords    = 16,
  parameter int unsigned MaxBurst      = 64,
  parameter logic [15:0] CfgRstVal     = 16'h8F1F
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        cs_ni,
  input  logic        ck_ena_i,
  input  logic [15:0] dq_i,
  input  logic [1:0]  rwds_i,
  output logic [15:0] dq_o,
  output logic        dq_oe_o,
  output logic [1:0]  rwds_o,
  output logic        rwds_oe_o,
  output logic        busy_o
);

  localparam logic [2:0] StIdle  = 3'd0;
  localparam logic [2:0] StCa    = 3'd1;
  localparam logic [2:0] StWait  = 3'd2;
  localparam logic [2:0] StRd    = 3'd3;
  localparam logic [2:0] StWr    = 3'd4;
  localparam logic [2:0] StRegWr = 3'd5;
  localparam logic [2:0] StDone  = 3'd6;

  localparam int unsigned Depth = 1 << AddrWidth;
  localparam int unsigned WaitW = $clog2(2 * LatencyCycles + 1);
  localparam logic [WaitW-1:0] WaitLast = WaitW'(2 * LatencyCycles - 1);
  localparam logic [AddrWidth-1:0] WrapMask = AddrWidth'(BurstWords - 1);

  logic [2:0]           r_state;
  logic [1:0]           r_caIdx;
  logic [WaitW-1:0]     r_waitCnt;
  logic                 r_isRead;
  logic                 r_isReg;
  logic                 r_isLinear;
  logic [AddrWidth-1:0] r_addrAcc;
  logic [AddrWidth-1:0] r_addr;
  logic [15:0]          r_cr0;
  logic [15:0]          r_dq;
  logic                 r_dqOe;
  logic [1:0]           r_rwds;
  logic                 r_rwdsOe;
  logic                 r_busy;
  logic [15:0]          r_mem [Depth];

  logic                 w_en;
  logic                 w_waitDone;
  logic                 w_memWr;
  logic                 w_overLimit;
  logic                 w_nextOver;
  logic [AddrWidth-1:0] w_caStart;
  logic [AddrWidth-1:0] w_incAddr;
  logic [AddrWidth-1:0] w_nextAddr;
  logic [15:0]          w_rdStart;
  logic [15:0]          w_rdNext;

  assign w_en       = !cs_ni && ck_ena_i;
  assign w_waitDone = (r_waitCnt == WaitLast);
  assign w_caStart  = r_addrAcc | AddrWidth'(dq_i[2:0]);
  assign w_incAddr  = r_addr + 1'b1;
  // Wrapped bursts only advance the bits below the burst boundary.
  assign w_nextAddr = r_isLinear ? w_incAddr : ((r_addr & ~WrapMask) | (w_incAddr & WrapMask));
  assign w_rdStart  = r_isReg ? r_cr0 : r_mem[r_addr];
  assign w_rdNext   = r_isReg ? r_cr0 : r_mem[w_nextAddr];
  assign w_memWr    = !rst_i && w_en && (r_state == StWr) && !w_overLimit;

`ifdef HYPERBUS_RESP_MAX_BURST_EN
  localparam int unsigned BeatW = $clog2(MaxBurst + 1);
  logic [BeatW-1:0] r_beatCnt;
  logic             w_startBurst;
  logic             w_beatAdv;

  assign w_startBurst = w_en && (r_state == StWait) && w_waitDone;
  assign w_beatAdv    = w_en && ((r_state == StRd) || (r_state == StWr));
  assign w_overLimit  = (r_beatCnt >= BeatW'(MaxBurst));
  assign w_nextOver   = (r_beatCnt >= BeatW'(MaxBurst - 1));

  always_ff @(posedge clk_i) begin
    if (rst_i || cs_ni || w_startBurst) begin
      r_beatCnt <= '0;
    end else if (w_beatAdv && !w_overLimit) begin
      r_beatCnt <= r_beatCnt + 1'b1;
    end
  end
`else
  assign w_overLimit = 1'b0;
  assign w_nextOver  = 1'b0;
`endif

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state    <= StIdle;
      r_caIdx    <= '0;
      r_waitCnt  <= '0;
      r_isRead   <= 1'b0;
      r_isReg    <= 1'b0;
      r_isLinear <= 1'b0;
      r_addrAcc  <= '0;
      r_addr     <= '0;
      r_cr0      <= CfgRstVal;
      r_dq       <= '0;
      r_dqOe     <= 1'b0;
      r_rwds     <= '0;
      r_rwdsOe   <= 1'b0;
      r_busy     <= 1'b0;
    end else if (cs_ni) begin
      r_state  <= StIdle;
      r_caIdx  <= '0;
      r_dqOe   <= 1'b0;
      r_rwds   <= '0;
      r_rwdsOe <= 1'b0;
      r_busy   <= 1'b0;
    end else begin
      if (r_state == StIdle) begin
        r_state  <= StCa;
        r_rwds   <= 2'b11;
        r_rwdsOe <= 1'b1;
        r_busy   <= 1'b1;
      end
      if (ck_ena_i) begin
        case (r_state)
          StIdle, StCa: begin
            case (r_caIdx)
              2'd0: begin
                r_isRead   <= dq_i[15];
                r_isReg    <= dq_i[14];
                r_isLinear <= dq_i[13];
                r_addrAcc  <= AddrWidth'({dq_i[12:0], 19'd0});
                r_caIdx    <= 2'd1;
              end
              2'd1: begin
                r_addrAcc <= r_addrAcc | AddrWidth'({dq_i, 3'd0});
                r_caIdx   <= 2'd2;
              end
              default: begin
                r_addr    <= w_caStart;
                r_waitCnt <= '0;
                r_rwds    <= '0;
                r_rwdsOe  <= 1'b0;
                r_state   <= (r_isReg && !r_isRead) ? StRegWr : StWait;
              end
            endcase
          end
          StWait: begin
            if (w_waitDone) begin
              // Beat 0 is prefetched so it is on the bus during its own enabled cycle.
              if (r_isRead) begin
                r_state  <= StRd;
                r_dq     <= w_rdStart;
                r_dqOe   <= 1'b1;
                r_rwds   <= 2'b10;
                r_rwdsOe <= 1'b1;
              end else begin
                r_state <= StWr;
              end
            end else begin
              r_waitCnt <= r_waitCnt + 1'b1;
            end
          end
          StRd: begin
            r_addr <= w_nextAddr;
            r_dq   <= w_rdNext;
            if (w_nextOver) begin
              r_dqOe   <= 1'b0;
              r_rwdsOe <= 1'b0;
            end
          end
          StWr: r_addr <= w_nextAddr;
          StRegWr: begin
            r_cr0   <= dq_i;
            r_state <= StDone;
          end
          default: ;
        endcase
      end
    end
  end

  // The array is deliberately left out of reset; only byte lanes with a clear mask are written.
  always_ff @(posedge clk_i) begin
    if (w_memWr) begin
      if (!rwds_i[1]) r_mem[r_addr][15:8] <= dq_i[15:8];
      if (!rwds_i[0]) r_mem[r_addr][7:0]  <= dq_i[7:0];
    end
  end

  assign dq_o      = r_dq;
  assign dq_oe_o   = r_dqOe;
  assign rwds_o    = r_rwds;
  assign rwds_oe_o = r_rwdsOe;
  assign busy_o    = r_busy;

endmodule
